// File: rtl/layer2_seq.sv
// layer2_seq: walks hidden indices for the layer-2 MAC array and aligns MAC start/stop
// with the buffer/ROM read latency; pulses done when the dot products are final.
module layer2_seq #(
   parameter int N_HIDDEN = 32,
   parameter int ADDR_W   = 5,
   parameter int RD_LAT   = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              go,
   input  logic              abort,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              mac_start,
   output logic              mac_stop,
   output logic              busy,
   output logic              done,
   output logic [7:0]        pass_cnt
);
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_HIDDEN - 1);
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [RD_LAT-1:0] vpipe_q, vpipe_d, fpipe_q, fpipe_d;
   logic [RD_LAT:0]   vsh, fsh;
   logic [7:0]        pass_cnt_q, pass_cnt_d;
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      rd_en      = state_q == ISSUE;
      rd_addr    = rd_en ? idx_q : '0;
      busy       = state_q != IDLE;
      done       = state_q == FIN && !abort;
      vsh        = {vpipe_q, rd_en};
      fsh        = {fpipe_q, rd_en && idx_q == '0};
      vpipe_d    = vsh[RD_LAT-1:0];
      fpipe_d    = fsh[RD_LAT-1:0];
      pass_cnt_d = pass_cnt_q + 8'(done);
      unique case (state_q)
         IDLE:  state_d = go ? ISSUE : IDLE;
         ISSUE: begin
            idx_d   = idx_q == LAST ? '0 : idx_q + ADDR_W'(1);
            state_d = idx_q == LAST ? DRAIN : ISSUE;
         end
         // leave once the last operand is the only one still in flight
         DRAIN: state_d = vpipe_d == '0 ? FIN : DRAIN;
         FIN:   state_d = IDLE;
      endcase
      if (abort) begin
         state_d = IDLE;
         idx_d   = '0;
         vpipe_d = '0;
         fpipe_d = '0;
      end
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         vpipe_q    <= '0;
         fpipe_q    <= '0;
         pass_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         vpipe_q    <= vpipe_d;
         fpipe_q    <= fpipe_d;
         pass_cnt_q <= pass_cnt_d;
      end
   assign mac_stop  = ~vpipe_q[RD_LAT-1];
   assign mac_start = fpipe_q[RD_LAT-1];
   assign pass_cnt  = pass_cnt_q;
endmodule

// File: tb/tb_layer2_seq.sv
// tb_layer2_seq: directed cycle tables for two sequencer configurations plus a small MAC model.
module tb_layer2_seq;
   logic clk = 1'b0, reset, go1, go2, abort;
   logic en1, st1, sp1, bz1, dn1, en2, st2, sp2, bz2, dn2;
   logic [4:0] addr1;
   logic [1:0] addr2;
   logic [7:0] pc1, pc2;
   always #5 clk = ~clk;
   layer2_seq u1 (.clk(clk), .reset(reset), .go(go1), .abort(abort), .rd_en(en1), .rd_addr(addr1),
      .mac_start(st1), .mac_stop(sp1), .busy(bz1), .done(dn1), .pass_cnt(pc1));
   layer2_seq #(.N_HIDDEN(4), .ADDR_W(2), .RD_LAT(3)) u2 (.clk(clk), .reset(reset), .go(go2),
      .abort(abort), .rd_en(en2), .rd_addr(addr2), .mac_start(st2), .mac_stop(sp2), .busy(bz2),
      .done(dn2), .pass_cnt(pc2));
   // MAC model: relu_out[k]=k, weight=1, registered reads of depth 1 and 3
   int op1, acc1, op2a, op2b, op2c, acc2;
   always @(posedge clk) begin
      op1  <= int'(addr1);
      op2a <= int'(addr2);
      op2b <= op2a;
      op2c <= op2b;
      if (!sp1) acc1 <= st1 ? op1 : acc1 + op1;
      if (!sp2) acc2 <= st2 ? op2c : acc2 + op2c;
   end
   typedef struct packed {logic en; logic [4:0] addr; logic st, sp, bz, dn; logic [7:0] pc;} obs_t;
   typedef struct {int run; int d; int cyc; obs_t exp;} vec_t;
   typedef struct {int n; int dsel; int go_until; int abort_at; int rst; int dones;} run_t;
   obs_t lg1[80], lg2[80];
   int acc1_lg[80], acc2_lg[80];
   vec_t vt[$];
   run_t rc[5];
   int checks = 0, failures = 0;
   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask
   function automatic void v(int run, int d, int cyc, logic en, int addr, logic st, logic sp,
                             logic bz, logic dn, int pc);
      vec_t e;
      e.run = run; e.d = d; e.cyc = cyc;
      e.exp.en = en; e.exp.addr = 5'(addr); e.exp.st = st; e.exp.sp = sp;
      e.exp.bz = bz; e.exp.dn = dn; e.exp.pc = 8'(pc);
      vt.push_back(e);
   endfunction
   task automatic do_run(input int r);
      int nd;
      if (rc[r].rst != 0) begin
         reset = 1'b1; go1 = 1'b0; go2 = 1'b0; abort = 1'b0;
         @(negedge clk);
         @(negedge clk);
         reset = 1'b0;
      end
      for (int c = 0; c < rc[r].n; c++) begin
         lg1[c] = {en1, addr1, st1, sp1, bz1, dn1, pc1};
         lg2[c] = {en2, {3'b000, addr2}, st2, sp2, bz2, dn2, pc2};
         acc1_lg[c] = acc1;
         acc2_lg[c] = acc2;
         go1   = rc[r].dsel == 0 && c <= rc[r].go_until;
         go2   = rc[r].dsel == 1 && c <= rc[r].go_until;
         abort = c == rc[r].abort_at;
         @(negedge clk);
      end
      go1 = 1'b0; go2 = 1'b0; abort = 1'b0;
      nd = 0;
      for (int c = 0; c < rc[r].n; c++) nd += int'(rc[r].dsel == 1 ? lg2[c].dn : lg1[c].dn);
      chk($sformatf("run%0d_done_count", r), nd, rc[r].dones);
      foreach (vt[i])
         if (vt[i].run == r)
            chk($sformatf("run%0d_dut%0d_cyc%0d", r, vt[i].d, vt[i].cyc),
                int'(vt[i].d == 1 ? lg2[vt[i].cyc] : lg1[vt[i].cyc]), int'(vt[i].exp));
   endtask
   initial begin
      int ns;
      reset = 1'b1; go1 = 1'b0; go2 = 1'b0; abort = 1'b0;
      rc[0] = '{72, 0, 35, -1, 1, 2};
      rc[1] = '{30, 0, 0, 10, 0, 0};
      rc[2] = '{36, 0, 0, -1, 0, 1};
      rc[3] = '{33, 0, 0, -1, 0, 0};
      rc[4] = '{12, 1, 0, -1, 1, 1};
      //   run dut cyc en addr st sp bz dn pc
      v(0, 0, 0,  0, 0,  0, 1, 0, 0, 0);
      v(0, 0, 1,  1, 0,  0, 1, 1, 0, 0);
      v(0, 0, 2,  1, 1,  1, 0, 1, 0, 0);
      v(0, 0, 3,  1, 2,  0, 0, 1, 0, 0);
      v(0, 0, 32, 1, 31, 0, 0, 1, 0, 0);
      v(0, 0, 33, 0, 0,  0, 0, 1, 0, 0);
      v(0, 0, 34, 0, 0,  0, 1, 1, 1, 0);
      v(0, 0, 35, 0, 0,  0, 1, 0, 0, 1);
      v(0, 0, 36, 1, 0,  0, 1, 1, 0, 1);
      v(0, 0, 37, 1, 1,  1, 0, 1, 0, 1);
      v(0, 0, 67, 1, 31, 0, 0, 1, 0, 1);
      v(0, 0, 68, 0, 0,  0, 0, 1, 0, 1);
      v(0, 0, 69, 0, 0,  0, 1, 1, 1, 1);
      v(0, 0, 70, 0, 0,  0, 1, 0, 0, 2);
      v(0, 0, 71, 0, 0,  0, 1, 0, 0, 2);
      v(1, 0, 0,  0, 0,  0, 1, 0, 0, 2);
      v(1, 0, 10, 1, 9,  0, 0, 1, 0, 2);
      v(1, 0, 11, 0, 0,  0, 1, 0, 0, 2);
      v(1, 0, 12, 0, 0,  0, 1, 0, 0, 2);
      v(1, 0, 29, 0, 0,  0, 1, 0, 0, 2);
      v(2, 0, 2,  1, 1,  1, 0, 1, 0, 2);
      v(2, 0, 34, 0, 0,  0, 1, 1, 1, 2);
      v(2, 0, 35, 0, 0,  0, 1, 0, 0, 3);
      v(3, 0, 32, 1, 31, 0, 0, 1, 0, 3);
      v(4, 1, 0,  0, 0,  0, 1, 0, 0, 0);
      v(4, 1, 1,  1, 0,  0, 1, 1, 0, 0);
      v(4, 1, 2,  1, 1,  0, 1, 1, 0, 0);
      v(4, 1, 4,  1, 3,  1, 0, 1, 0, 0);
      v(4, 1, 5,  0, 0,  0, 0, 1, 0, 0);
      v(4, 1, 7,  0, 0,  0, 0, 1, 0, 0);
      v(4, 1, 8,  0, 0,  0, 1, 1, 1, 0);
      v(4, 1, 9,  0, 0,  0, 1, 0, 0, 1);
      do_run(0);
      for (int c = 1; c <= 32; c++) chk($sformatf("run0_addr_cyc%0d", c), int'(lg1[c].addr), c - 1);
      for (int c = 0; c <= 35; c++) chk($sformatf("run0_stop_cyc%0d", c), int'(lg1[c].sp), int'(!(c >= 2 && c <= 33)));
      ns = 0;
      for (int c = 0; c < 72; c++) ns += int'(lg1[c].st);
      chk("run0_start_count", ns, 2);
      chk("run0_sum_pass1", acc1_lg[34], 496);
      chk("run0_sum_pass2", acc1_lg[69], 496);
      do_run(1);
      do_run(2);
      chk("run2_sum_after_abort", acc1_lg[34], 496);
      do_run(3);
      // now in cycle 33 of a pass (DRAIN); reset must act without a clock edge
      chk("drain_busy", int'(bz1), 1);
      chk("drain_rd_en", int'(en1), 0);
      reset = 1'b1;
      #1;
      chk("async_rst_obs", int'({en1, addr1, st1, sp1, bz1, dn1, pc1}), int'({1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0}));
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk($sformatf("post_rst_idle_cyc%0d", c), int'({en1, bz1, dn1, sp1}), int'(4'b0001));
      end
      do_run(4);
      chk("lat3_sum", acc2_lg[8], 6);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
